muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; the block is fixed at 32-bit operands and 32 iterations.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-low; sampled on posedge clk; low = reset.
REQ-004 start  in  1  request a new operation; sampled on posedge clk.
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  in  32  operand A (multiplicand/dividend) from the register file read port 1; also the MTHI/MTLO source.
REQ-007 rt_data  in  32  operand B (multiplier/divisor) from the register file read port 2.
REQ-008 mthi  in  1  write rs_data into HI.
REQ-009 mtlo  in  1  write rs_data into LO.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-012 hi  out  32  HI register: product upper half or remainder.
REQ-013 lo  out  32  LO register: product lower half or quotient.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE; a 5-bit iteration counter SHALL run only in RUN.
REQ-015 In IDLE or DONE with start=1 at an edge, the block SHALL latch |A|, |B|, the result-sign flags and the op; clear the counter; and enter RUN. Signed ops use two's-complement magnitude; unsigned ops use raw operands.
REQ-016 In IDLE or DONE with start=0 at an edge, the block SHALL go to IDLE.
REQ-017 RUN SHALL perform one iteration per cycle, for exactly 32 cycles:
- multiply: radix-2 shift-add over a 64-bit accumulator;
- divide: restoring, 1 quotient bit per cycle.
REQ-018 On the edge that ends the 32nd RUN cycle, the block SHALL write the sign-corrected result to hi/lo and enter DONE.
REQ-019 Latency: if start is sampled at edge E0, hi/lo SHALL update at E32 and done SHALL be high during the cycle following E32 only.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both are registered-state decodes.
REQ-021 MULT SHALL produce the 64-bit signed product; MULTU the 64-bit unsigned product; {hi,lo} = product.
REQ-022 Division sign rules:
- DIV quotient is negative iff the operand signs differ;
- the remainder takes the sign of the dividend;
- the quotient truncates toward zero.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (32-bit truncation, no trap).
REQ-024 Divisor = 0 (DIV or DIVU) SHALL give hi=rs_data as latched at start and lo=0xFFFFFFFF, with no sign correction and unchanged 32-cycle latency.
REQ-025 start sampled in RUN SHALL be ignored; the operands and op in flight SHALL not change.
REQ-026 mthi/mtlo sampled in IDLE or DONE SHALL write rs_data to hi/lo respectively.
- If both are high, both registers are written.
- If start is also high, start wins and mthi/mtlo are ignored.
REQ-027 mthi/mtlo sampled in RUN SHALL be ignored.
REQ-028 op, rs_data and rt_data SHALL be don't-care except at the start edge (and rs_data at mthi/mtlo edges).

Reset
REQ-029 reset=0 at any edge, including mid-RUN, SHALL force:
- state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0;
- any in-flight operation is abandoned and produces no done pulse.
REQ-030 reset SHALL take priority over start, mthi and mtlo in the same cycle.
REQ-031 The first edge with reset=1 SHALL process inputs normally.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 32 cycles; done 32 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 0x64 / 0 -> hi=0x00000064, lo=0xFFFFFFFF.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-036 Start MULTU 3x4, then:
- start=1 and mthi (rs_data=0xDEAD) at RUN cycle 5 -> both ignored, hi=0, lo=0x0C at done;
- re-run the op and drive reset=0 at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse.
REQ-037 Back-to-back: start high in the DONE cycle -> the new op is accepted and busy=1 on the next cycle; mthi+mtlo together in IDLE with rs_data=0x12345678 -> hi=lo=0x12345678.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring-divide step per cycle, 32 cycles per op.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_step;
  logic [31:0] opnd;
  logic        is_div, div0, neg_q, neg_r;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, shl;
  logic [31:0] diff, q, r, res_hi, res_lo;
  logic [63:0] prod;

  // Operand magnitudes; op[0]=1 selects the unsigned variants.
  always_comb begin
    a_neg = ~op[0] & rs_data[31];
    b_neg = ~op[0] & rt_data[31];
    a_mag = a_neg ? -rs_data : rs_data;
    b_mag = b_neg ? -rt_data : rt_data;
  end

  // acc holds {product high, multiplier/product low} or {remainder, dividend/quotient}.
  always_comb begin
    sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    shl  = {acc[63:32], acc[31]};
    diff = shl[31:0] - opnd;
    if (!is_div)
      acc_step = {sum, acc[31:1]};
    else if (shl >= {1'b0, opnd})
      acc_step = {diff, acc[30:0], 1'b1};
    else
      acc_step = {shl[31:0], acc[30:0], 1'b0};
  end

  // A zero divisor leaves |A| in the remainder, so the dividend sign restores rs_data.
  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    q    = acc_step[31:0];
    r    = acc_step[63:32];
    if (is_div) begin
      res_lo = div0 ? 32'hFFFF_FFFF : (neg_q ? -q : q);
      res_hi = neg_r ? -r : r;
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? RUN : IDLE;
      RUN:        if (cnt == 5'd31) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (start) begin
        cnt    <= '0;
        is_div <= op[1];
        opnd   <= op[1] ? b_mag : a_mag;
        acc    <= {32'd0, op[1] ? a_mag : b_mag};
        div0   <= (rt_data == 32'd0);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= op[1] & a_neg;
      end else begin
        if (mthi) hi <= rs_data;
        if (mtlo) lo <= rs_data;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
